// File: rtl/mod_freq_defs_pkg.sv
// Shared definitions for the modulation-frequency sequencer: FSM encoding, divisor legality, clog2.
// Optional build macro used by the sequencer: MFS_CONTINUOUS_EN (loop the table until stopped).
package mod_freq_defs;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } mfs_state_t;

    // Divisors 0 and 1 are illegal for the divider and mark the end of the table.
    localparam int MIN_VALID_DIVISOR = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/mod_freq_sequencer_step_table.sv
// Step table: NUM_STEPS entries of {divisor, hold}, one synchronous write port, one async read port.
module mod_freq_step_table #(
    parameter int DIVISOR_BITS = 8,
    parameter int HOLD_BITS    = 16,
    parameter int NUM_STEPS    = 4,
    parameter int STEP_BITS    = 2
) (
    input  logic                    clk_in,
    input  logic                    we_i,
    input  logic [STEP_BITS-1:0]    waddr_i,
    input  logic [DIVISOR_BITS-1:0] wdiv_i,
    input  logic [HOLD_BITS-1:0]    whold_i,
    input  logic [STEP_BITS-1:0]    raddr_i,
    output logic [DIVISOR_BITS-1:0] rdiv_o,
    output logic [HOLD_BITS-1:0]    rhold_o
);

    // Deliberately not reset: the programmed table survives a sequencer reset.
    logic [DIVISOR_BITS-1:0] div_mem_q  [NUM_STEPS];
    logic [HOLD_BITS-1:0]    hold_mem_q [NUM_STEPS];

    always_ff @(posedge clk_in) begin
        if (we_i) begin
            div_mem_q[waddr_i]  <= wdiv_i;
            hold_mem_q[waddr_i] <= whold_i;
        end
    end

    assign rdiv_o  = div_mem_q[raddr_i];
    assign rhold_o = hold_mem_q[raddr_i];

endmodule

// File: rtl/mod_freq_sequencer.sv
// Steps a modulation clock divider through a programmed table of divisors, resetting it on each change.
// Build macro MFS_CONTINUOUS_EN: wrap to entry 0 after the last valid entry until stopped (no done).
module mod_freq_sequencer
    import mod_freq_defs::*;
#(
    parameter int DIVISOR_BITS  = 8,
    parameter int NUM_STEPS     = 4,
    parameter int HOLD_BITS     = 16,
    parameter int SETTLE_CYCLES = 2,
    localparam int STEP_BITS    = clog2(NUM_STEPS)
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [STEP_BITS-1:0]    cfg_addr,
    input  logic [DIVISOR_BITS-1:0] cfg_divisor,
    input  logic [HOLD_BITS-1:0]    cfg_hold,
    input  logic                    start,
    input  logic                    stop,
    output logic [DIVISOR_BITS-1:0] divisor,
    output logic                    div_rst,
    output logic [STEP_BITS-1:0]    step_idx,
    output logic                    busy,
    output logic                    done
);

    localparam int SC_BITS = clog2(SETTLE_CYCLES) + 1;
    localparam logic [SC_BITS-1:0]   SETTLE_LOAD = SC_BITS'(SETTLE_CYCLES - 1);
    localparam logic [STEP_BITS-1:0] LAST_IDX    = STEP_BITS'(NUM_STEPS - 1);

    mfs_state_t              state_q;
    logic [DIVISOR_BITS-1:0] divisor_q;
    logic                    div_rst_q;
    logic [STEP_BITS-1:0]    step_q;
    logic                    busy_q;
    logic                    done_q;
    logic [SC_BITS-1:0]      settle_q;
    logic [HOLD_BITS-1:0]    hold_q;
`ifdef MFS_CONTINUOUS_EN
    logic [DIVISOR_BITS-1:0] first_div_q;
`endif

    logic [STEP_BITS-1:0]    rd_addr;
    logic [STEP_BITS-1:0]    next_idx;
    logic [DIVISOR_BITS-1:0] rd_div;
    logic [HOLD_BITS-1:0]    rd_hold;
    logic                    rd_valid;
    logic                    has_next;
    logic [HOLD_BITS-1:0]    hold_load;

    mod_freq_step_table #(
        .DIVISOR_BITS (DIVISOR_BITS),
        .HOLD_BITS    (HOLD_BITS),
        .NUM_STEPS    (NUM_STEPS),
        .STEP_BITS    (STEP_BITS)
    ) u_table (
        .clk_in  (clk_in),
        .we_i    (cfg_we && !busy_q),
        .waddr_i (cfg_addr),
        .wdiv_i  (cfg_divisor),
        .whold_i (cfg_hold),
        .raddr_i (rd_addr),
        .rdiv_o  (rd_div),
        .rhold_o (rd_hold)
    );

    // The read port looks ahead: entry 0 in IDLE, the following entry during RUN.
    always_comb begin
        next_idx  = (step_q == LAST_IDX) ? '0 : step_q + 1'b1;
        rd_addr   = step_q;
        if (state_q == ST_IDLE)     rd_addr = '0;
        else if (state_q == ST_RUN) rd_addr = next_idx;
        rd_valid  = (rd_div >= DIVISOR_BITS'(MIN_VALID_DIVISOR));
        has_next  = (step_q != LAST_IDX) && rd_valid;
        hold_load = (rd_hold == '0) ? HOLD_BITS'(1) : rd_hold;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            divisor_q <= '0;
            div_rst_q <= 1'b1;
            step_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            settle_q  <= '0;
            hold_q    <= '0;
`ifdef MFS_CONTINUOUS_EN
            first_div_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    div_rst_q <= 1'b1;
                    if (start && !stop) begin
                        step_q <= '0;
                        if (rd_valid) begin
                            state_q   <= ST_SETTLE;
                            busy_q    <= 1'b1;
                            divisor_q <= rd_div;
                            settle_q  <= SETTLE_LOAD;
`ifdef MFS_CONTINUOUS_EN
                            first_div_q <= rd_div;
`endif
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (stop) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        div_rst_q <= 1'b1;
                    end else if (settle_q == '0) begin
                        state_q   <= ST_RUN;
                        div_rst_q <= 1'b0;
                        hold_q    <= hold_load;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        div_rst_q <= 1'b1;
                    end else if (hold_q <= HOLD_BITS'(1)) begin
                        div_rst_q <= 1'b1;
                        if (has_next) begin
                            state_q   <= ST_SETTLE;
                            step_q    <= next_idx;
                            divisor_q <= rd_div;
                            settle_q  <= SETTLE_LOAD;
                        end else begin
`ifdef MFS_CONTINUOUS_EN
                            // Entry 0 was valid at start and the table is locked while busy.
                            state_q   <= ST_SETTLE;
                            step_q    <= '0;
                            divisor_q <= first_div_q;
                            settle_q  <= SETTLE_LOAD;
`else
                            state_q   <= ST_IDLE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
`endif
                        end
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                    div_rst_q <= 1'b1;
                end
            endcase
        end
    end

    assign divisor  = divisor_q;
    assign div_rst  = div_rst_q;
    assign step_idx = step_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_mod_freq_sequencer.sv
// Directed bench for mod_freq_sequencer; the continuous-loop scenario builds with MFS_CONTINUOUS_EN.
module tb_mod_freq_sequencer;

    logic        clk_in;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_divisor;
    logic [15:0] cfg_hold;
    logic        start;
    logic        stop;
    logic [7:0]  divisor;
    logic        div_rst;
    logic [1:0]  step_idx;
    logic        busy;
    logic        done;

    int tests_run;
    int tests_failed;

    mod_freq_sequencer dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_divisor (cfg_divisor),
        .cfg_hold    (cfg_hold),
        .start       (start),
        .stop        (stop),
        .divisor     (divisor),
        .div_rst     (div_rst),
        .step_idx    (step_idx),
        .busy        (busy),
        .done        (done)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic write_entry(input int addr, input int dv, input int hd);
        cfg_we      = 1'b1;
        cfg_addr    = 2'(addr);
        cfg_divisor = 8'(dv);
        cfg_hold    = 16'(hd);
        tick();
        cfg_we      = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_full_table();
        write_entry(0, 4, 10);
        write_entry(1, 6, 5);
        write_entry(2, 8, 3);
        write_entry(3, 10, 1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests_run++; if (divisor !== 8'd0) begin tests_failed++; $display("FAIL reset_divisor got %0d exp 0", divisor); end
        tests_run++; if (div_rst !== 1'b1) begin tests_failed++; $display("FAIL reset_div_rst got %b exp 1", div_rst); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b exp 0", done); end
        tests_run++; if (step_idx !== 2'd0) begin tests_failed++; $display("FAIL reset_step_idx got %0d exp 0", step_idx); end
        rst_n = 1'b1;
        tick();
        write_entry(0, 4, 10);
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        tests_run++; if (divisor !== 8'd4) begin tests_failed++; $display("FAIL reset_table_kept got %0d exp 4", divisor); end
        tests_run++; if ({div_rst, busy} !== 2'b11) begin tests_failed++; $display("FAIL reset_start_state got %b exp 11", {div_rst, busy}); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_stop_busy got %b exp 0", busy); end
    endtask

    task automatic test_full_pass();
        logic [7:0]  dv [4] = '{8'd4, 8'd6, 8'd8, 8'd10};
        int          hd [4] = '{10, 5, 3, 1};
        logic [12:0] exp_v;
        load_full_table();
        pulse_start();
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 2; c++) begin
                exp_v = {dv[s], 1'b1, 1'b1, 1'b0, 2'(s)};
                tests_run++;
                if ({divisor, div_rst, busy, done, step_idx} !== exp_v) begin
                    tests_failed++;
                    $display("FAIL full_pass_settle s%0d c%0d got %h exp %h", s, c, {divisor, div_rst, busy, done, step_idx}, exp_v);
                end
                tick();
            end
            for (int c = 0; c < hd[s]; c++) begin
                exp_v = {dv[s], 1'b0, 1'b1, 1'b0, 2'(s)};
                tests_run++;
                if ({divisor, div_rst, busy, done, step_idx} !== exp_v) begin
                    tests_failed++;
                    $display("FAIL full_pass_run s%0d c%0d got %h exp %h", s, c, {divisor, div_rst, busy, done, step_idx}, exp_v);
                end
                tick();
            end
        end
        tests_run++; if ({done, busy, div_rst} !== 3'b101) begin tests_failed++; $display("FAIL full_pass_end got %b exp 101", {done, busy, div_rst}); end
        tick();
        tests_run++; if ({done, busy} !== 2'b00) begin tests_failed++; $display("FAIL full_pass_after got %b exp 00", {done, busy}); end
    endtask

    task automatic test_end_marker();
        logic [7:0]  dv [2] = '{8'd4, 8'd6};
        int          hd [2] = '{2, 0};
        int          eff;
        logic [11:0] exp_v;
        write_entry(0, 4, 2);
        write_entry(1, 6, 0);
        write_entry(2, 1, 5);
        pulse_start();
        for (int s = 0; s < 2; s++) begin
            eff = (hd[s] == 0) ? 1 : hd[s];
            for (int c = 0; c < 2 + eff; c++) begin
                exp_v = {dv[s], (c < 2), 1'b0, 2'(s)};
                tests_run++;
                if ({divisor, div_rst, done, step_idx} !== exp_v) begin
                    tests_failed++;
                    $display("FAIL end_marker s%0d c%0d got %h exp %h", s, c, {divisor, div_rst, done, step_idx}, exp_v);
                end
                tick();
            end
        end
        tests_run++; if ({done, busy} !== 2'b10) begin tests_failed++; $display("FAIL end_marker_done got %b exp 10", {done, busy}); end
        tests_run++; if (divisor == 8'd1) begin tests_failed++; $display("FAIL end_marker_div got %0d exp not 1", divisor); end
        tick();
        write_entry(0, 0, 5);
        pulse_start();
        tests_run++; if ({done, busy} !== 2'b10) begin tests_failed++; $display("FAIL entry0_invalid_done got %b exp 10", {done, busy}); end
        tick();
        tests_run++; if ({done, busy} !== 2'b00) begin tests_failed++; $display("FAIL entry0_invalid_after got %b exp 00", {done, busy}); end
    endtask

    task automatic test_abort();
        load_full_table();
        pulse_start();
        repeat (16) tick();
        tests_run++; if ({step_idx, div_rst} !== 3'b010) begin tests_failed++; $display("FAIL abort_pre got %b exp 010", {step_idx, div_rst}); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tests_run++; if ({busy, div_rst, done} !== 3'b010) begin tests_failed++; $display("FAIL abort_mid got %b exp 010", {busy, div_rst, done}); end
        tick();
        tests_run++; if ({busy, done} !== 2'b00) begin tests_failed++; $display("FAIL abort_mid_after got %b exp 00", {busy, done}); end
        pulse_start();
        repeat (26) tick();
        tests_run++; if ({step_idx, div_rst} !== 3'b110) begin tests_failed++; $display("FAIL abort_expiry_pre got %b exp 110", {step_idx, div_rst}); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tests_run++; if ({busy, div_rst, done} !== 3'b010) begin tests_failed++; $display("FAIL abort_expiry got %b exp 010", {busy, div_rst, done}); end
        tick();
        tests_run++; if ({busy, done} !== 2'b00) begin tests_failed++; $display("FAIL abort_expiry_after got %b exp 00", {busy, done}); end
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        tests_run++; if ({busy, done} !== 2'b00) begin tests_failed++; $display("FAIL start_stop_idle got %b exp 00", {busy, done}); end
    endtask

    task automatic test_config_lock();
        load_full_table();
        pulse_start();
        repeat (15) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++; if ({busy, step_idx, div_rst, divisor} !== {1'b1, 2'd1, 1'b0, 8'd6}) begin
            tests_failed++; $display("FAIL start_while_busy got %b exp %b", {busy, step_idx, div_rst, divisor}, {1'b1, 2'd1, 1'b0, 8'd6});
        end
        write_entry(0, 200, 7);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        pulse_start();
        tests_run++; if (divisor !== 8'd4) begin tests_failed++; $display("FAIL cfg_lock_div got %0d exp 4", divisor); end
        repeat (2) tick();
        repeat (9) begin
            tick();
        end
        tests_run++; if ({div_rst, step_idx} !== 3'b000) begin tests_failed++; $display("FAIL cfg_lock_hold got %b exp 000", {div_rst, step_idx}); end
        tick();
        tests_run++; if ({div_rst, step_idx} !== 3'b101) begin tests_failed++; $display("FAIL cfg_lock_next got %b exp 101", {div_rst, step_idx}); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

`ifdef MFS_CONTINUOUS_EN
    task automatic test_continuous();
        logic [7:0]  dv [2] = '{8'd4, 8'd6};
        int          hd [2] = '{2, 1};
        logic [11:0] exp_v;
        write_entry(0, 4, 2);
        write_entry(1, 6, 1);
        write_entry(2, 0, 1);
        pulse_start();
        for (int loop = 0; loop < 3; loop++) begin
            for (int s = 0; s < 2; s++) begin
                for (int c = 0; c < 2 + hd[s]; c++) begin
                    exp_v = {dv[s], (c < 2), 1'b0, 2'(s)};
                    tests_run++;
                    if ({divisor, div_rst, done, step_idx} !== exp_v) begin
                        tests_failed++;
                        $display("FAIL continuous l%0d s%0d c%0d got %h exp %h", loop, s, c, {divisor, div_rst, done, step_idx}, exp_v);
                    end
                    tick();
                end
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tests_run++; if ({busy, done, div_rst} !== 3'b001) begin tests_failed++; $display("FAIL continuous_stop got %b exp 001", {busy, done, div_rst}); end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        cfg_we       = 1'b0;
        cfg_addr     = '0;
        cfg_divisor  = '0;
        cfg_hold     = '0;
        start        = 1'b0;
        stop         = 1'b0;
        test_reset();
`ifdef MFS_CONTINUOUS_EN
        test_abort();
        test_config_lock();
        test_continuous();
`else
        test_full_pass();
        test_end_marker();
        test_abort();
        test_config_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
